// File: rtl/character_fsm_if.sv
// Character-stream interface for character_fsm.
//   in  : 8-bit ASCII character, one per clock (driven by the stream source)
//   cnt : registered count of completed "BUAA" matches (driven by the FSM)
// master modport is the stream source / count observer, slave is the FSM.
interface character_fsm_if #(
    parameter int unsigned CNT_W = 8
);
    logic [7:0]       in;
    logic [CNT_W-1:0] cnt;

    modport master (
        output in,
        input  cnt
    );

    modport slave (
        input  in,
        output cnt
    );
endinterface

// File: rtl/character_fsm.sv
// Counts complete occurrences of the keyword "BUAA" (case-sensitive) in an
// ASCII stream sampled one character per rising clock edge.
//   clk   : single clock, all state changes on the rising edge
//   reset : synchronous active-high reset (state -> IDLE, count -> 0)
//   bus   : slave side of character_fsm_if (in: character, cnt: match count)
// The count is registered, saturates at 2^CNT_W-1 and never wraps.
module character_fsm #(
    parameter int unsigned CNT_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    character_fsm_if.slave  bus
);

    localparam logic [7:0] CharB = 8'h42;
    localparam logic [7:0] CharU = 8'h55;
    localparam logic [7:0] CharA = 8'h41;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] S_B   = 2'd1;
    localparam logic [1:0] S_BU  = 2'd2;
    localparam logic [1:0] S_BUA = 2'd3;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [1:0]       state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        state_d = IDLE;
        cnt_d   = cnt_q;
        // A 'B' always restarts the prefix, whatever was seen before.
        if (bus.in == CharB) begin
            state_d = S_B;
        end else begin
            case (state_q)
                S_B:     if (bus.in == CharU) state_d = S_BU;
                S_BU:    if (bus.in == CharA) state_d = S_BUA;
                S_BUA: begin
                    if (bus.in == CharA && cnt_q != CntMax) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.cnt = cnt_q;

endmodule

// File: tb/tb_character_fsm.sv
// Directed testbench for character_fsm: drives characters, checks the count
// against hand-computed expectations after each relevant edge.
module tb_character_fsm;

    localparam int unsigned CNT_W = 8;

    logic clk;
    logic reset;

    character_fsm_if #(.CNT_W(CNT_W)) bus ();

    character_fsm #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one character across one rising edge; outputs sampled 1 ns after.
    task automatic send(input logic [7:0] c);
        bus.in = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_chk(input logic [7:0] c, input int exp, input string tag);
        send(c);
        check(tag, int'(bus.cnt), exp);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    initial begin
        reset  = 1'b1;
        bus.in = 8'h00;

        // Reset held with in = 0x00.
        for (int i = 0; i < 4; i++) begin
            send(8'h00);
            check("reset_hold", int'(bus.cnt), 0);
        end
        reset = 1'b0;
        send_chk(8'h00, 0, "after_release");

        // "#BUAAX BUA?" : count steps 0->1 on the second 'A' only.
        send_chk("#", 0, "seq1_hash");
        send_chk("B", 0, "seq1_B");
        send_chk("U", 0, "seq1_U");
        send_chk("A", 0, "seq1_A1");
        send_chk("A", 1, "seq1_A2");
        send_chk("X", 1, "seq1_X");
        send_chk(" ", 1, "seq1_sp");
        send_chk("B", 1, "seq1_B2");
        send_chk("U", 1, "seq1_U2");
        send_chk("A", 1, "seq1_A3");
        send_chk("?", 1, "seq1_q");

        // Back-to-back matches.
        send_str("BUAA");
        check("b2b_first", int'(bus.cnt), 2);
        send_str("BUAA");
        check("b2b_second", int'(bus.cnt), 3);

        send_str("BBUAA");
        check("restart_BB", int'(bus.cnt), 4);
        send_str("BUBUAA");
        check("restart_BUB", int'(bus.cnt), 5);

        send_str("buaa");
        check("lowercase", int'(bus.cnt), 5);
        send_str("BUAa");
        check("last_lower", int'(bus.cnt), 5);
        send_str("BU");
        send_chk(8'h00, 5, "nul_break");
        send_chk("A", 5, "nul_break_A");

        // Reset discards a partial prefix.
        send_str("BUA");
        reset = 1'b1;
        send_chk("Z", 0, "reset_mid");
        reset = 1'b0;
        send_chk("A", 0, "prefix_discard");

        // Reset on the same edge as a completing 'A'.
        send_str("BUAA");
        check("pre_collide", int'(bus.cnt), 1);
        send_str("BUA");
        reset = 1'b1;
        send_chk("A", 0, "reset_vs_match");

        // Characters sampled under reset never form part of a match.
        send_str("BUA");
        reset = 1'b0;
        send_chk("A", 0, "chars_in_reset");

        // Saturation.
        for (int i = 0; i < 254; i++) send_str("BUAA");
        check("sat_254", int'(bus.cnt), 254);
        send_str("BUAA");
        check("sat_255", int'(bus.cnt), 255);
        send_str("BUAA");
        check("sat_hold1", int'(bus.cnt), 255);
        send_str("BUAABUAA");
        check("sat_hold2", int'(bus.cnt), 255);

        reset = 1'b1;
        send_chk("B", 0, "final_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
